// File: rtl/lfsr_interval_timer_if.sv
// Control/status bundle for lfsr_interval_timer.
// The master side drives the controls and the slave side is the timer.
interface lfsr_interval_timer_if #(
    parameter int WIDTH = 16
);
    logic             enable;
    logic             start;
    logic             stop;
    logic             periodic;
    logic             term_we;
    logic [WIDTH-1:0] term_din;
    logic             timeout;
    logic             busy;
    logic [WIDTH-1:0] lfsr_q;
    logic             lockup_err;

    modport master (
        output enable, start, stop, periodic, term_we, term_din,
        input  timeout, busy, lfsr_q, lockup_err
    );

    modport slave (
        input  enable, start, stop, periodic, term_we, term_din,
        output timeout, busy, lfsr_q, lockup_err
    );
endinterface

// File: rtl/lfsr_interval_timer.sv
// Galois XNOR LFSR interval timer with a programmable terminal state and one-shot or periodic re-arm.
// Lock-up recovery from the all-ones state is compiled in by defining LFSR_TIMER_LOCKUP_EN.
module lfsr_interval_timer #(
    parameter int               WIDTH    = 16,
    parameter logic [31:0]      TAPS     = 32'h0000_002C,
    parameter logic [WIDTH-1:0] SEED     = '0,
    parameter logic [WIDTH-1:0] TERMINAL = WIDTH'(32'h2493)
) (
    input logic                  clk,
    input logic                  rst,
    lfsr_interval_timer_if.slave bus
);
    // state    | meaning
    // ST_IDLE  | lfsr parked at SEED, busy low
    // ST_RUN   | lfsr stepping toward term_reg
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] lfsr_step;
    logic [WIDTH-1:0] term_reg;
    logic             periodic_q;
    logic             timeout_r;
    logic             lockup_r;
    logic             running;
    logic             match;
    logic             lockup_hit;

    assign running = (state == ST_RUN);
    assign match   = running && (lfsr == term_reg);

`ifdef LFSR_TIMER_LOCKUP_EN
    // An all-ones terminal is matched before recovery could fire.
    assign lockup_hit = running && (&lfsr) && !(&term_reg);
`else
    assign lockup_hit = 1'b0;
`endif

    always_comb begin
        lfsr_step    = '0;
        lfsr_step[0] = lfsr[WIDTH-1];
        for (int i = 1; i < WIDTH; i++) begin
            if (TAPS[i])
                lfsr_step[i] = lfsr[i-1] ~^ lfsr[WIDTH-1];
            else
                lfsr_step[i] = lfsr[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            lfsr       <= SEED;
            term_reg   <= TERMINAL;
            periodic_q <= 1'b0;
            timeout_r  <= 1'b0;
            lockup_r   <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            lockup_r  <= 1'b0;
            if (bus.term_we)
                term_reg <= bus.term_din;

            if (bus.stop) begin
                state <= ST_IDLE;
                lfsr  <= SEED;
            end else if (bus.start) begin
                state      <= ST_RUN;
                lfsr       <= SEED;
                periodic_q <= bus.periodic;
            end else if (match) begin
                timeout_r <= 1'b1;
                lfsr      <= SEED;
                state     <= periodic_q ? ST_RUN : ST_IDLE;
            end else if (lockup_hit) begin
                lockup_r <= 1'b1;
                lfsr     <= SEED;
            end else if (running && bus.enable) begin
                lfsr <= lfsr_step;
            end
        end
    end

    assign bus.timeout    = timeout_r;
    assign bus.busy       = running;
    assign bus.lfsr_q     = lfsr;
    assign bus.lockup_err = lockup_r;
endmodule

// File: doc/lfsr_interval_timer.md
# lfsr_interval_timer

Parametrised successor to the fixed 16-bit LFSR millisecond timer. It is a Galois XNOR LFSR interval timer with configurable width, feedback taps, seed and a runtime-programmable terminal state. It adds one-shot/periodic modes, explicit start/stop control and optional lock-up recovery. It sits behind a prescaler, which drives `enable`, and feeds game/FSM timeouts with single-cycle pulses.

## Interface
- `WIDTH`, 16, LFSR width in bits; legal range 4..32.
- `TAPS`, 16'h002C, XNOR tap mask. Bit i (i≥1) set: `lfsr[i] <= lfsr[i-1] ~^ lfsr[WIDTH-1]`. Bit i clear: `lfsr[i] <= lfsr[i-1]`. Always `lfsr[0] <= lfsr[WIDTH-1]`. Bit 0 of `TAPS` is ignored.
- `SEED`, 0, reload value at start, stop and every match. Must not be all-ones.
- `TERMINAL`, 16'h2493, reset value of the terminal register.
- `clk  in  1  clock; all logic on rising edge`
- `rst  in  1  synchronous, active-high reset`
- `enable  in  1  step qualifier; LFSR advances only when high`
- `start  in  1  arm/restart pulse; samples periodic`
- `stop  in  1  abort; return to IDLE`
- `periodic  in  1  1 = auto-rearm after timeout, 0 = one-shot`
- `term_we  in  1  write term_din into terminal register`
- `term_din  in  WIDTH  new terminal state`
- `timeout  out  1  registered one-cycle pulse on terminal match`
- `busy  out  1  high in RUN`
- `lfsr_q  out  WIDTH  current LFSR state`
- `lockup_err  out  1  registered one-cycle pulse on lock-up recovery`

## Operation
- States: IDLE, RUN. Internal registers: `lfsr`, `term_reg`, `periodic_q`.
- IDLE: `lfsr` is held at `SEED` and `busy` = 0.
- Per-cycle priority: `rst` > `stop` > `start` > match > lock-up > step.
- `stop`: go to IDLE and load `lfsr <= SEED`. No pulse is issued, even if a match is present the same cycle.
- `start` (from IDLE or RUN): go to RUN, load `lfsr <= SEED`, capture `periodic_q <= periodic`. A match in the same cycle is suppressed (restart).
- Match: in RUN with `lfsr == term_reg`. Effects: `timeout` pulses, `lfsr <= SEED`, and the state goes to RUN if `periodic_q`, otherwise IDLE. The match is evaluated regardless of `enable`.
- Step: in RUN, with no match and `enable` = 1, apply the tap equations. With `enable` = 0, `lfsr` holds.
- Terminal register:
  - `term_we` loads `term_reg <= term_din` in any state.
  - The compare in the write cycle uses the old value.
- Terminal equal to `SEED`: a match occurs on every RUN cycle, giving a 1-cycle period.
- Terminal not reachable from `SEED`: the block never times out. This is legal; software is responsible for avoiding it.
- Lock-up: the all-ones state is self-looping under XNOR feedback. Handling is set by the macro in Configuration.

## Timing
- Reset values: `timeout` = 0, `busy` = 0, `lockup_err` = 0, `lfsr_q` = `SEED`, `term_reg` = `TERMINAL`, `periodic_q` = 0, state IDLE.
- `timeout` and `lockup_err` are high for exactly one cycle per event and are cleared on all other cycles.
- Let N be the number of steps from `SEED` to `term_reg`, with `enable` held high.
- If `start` is sampled at edge k, `timeout` is high after edge k+N+1.
- Periodic mode: pulses repeat every N+1 cycles.
- Each cycle with `enable` low inside the interval adds one cycle to the interval.
- `busy` rises after the `start` edge. In one-shot mode it falls on the same edge that raises `timeout`.

## Configuration
- Macro: `LFSR_TIMER_LOCKUP_EN`.
- Defined:
  - In RUN, with `lfsr` all-ones and `term_reg` not all-ones, the next edge loads `lfsr <= SEED` and pulses `lockup_err`. The state stays RUN.
  - Match takes priority over lock-up.
- Undefined:
  - `lockup_err` is tied to 0.
  - An all-ones `lfsr` stays stuck until `stop`, `start` or `rst`.

## Test plan
Benches use `WIDTH`=4, `TAPS`=4'h2, `SEED`=0 unless stated. The sequence from 0 is 0x0→0x2→0x6→0xE→0xD.

- Reset and one-shot:
  - `rst` gives all outputs at their reset values.
  - Write terminal 0xE, `periodic`=0, `start` at edge k with `enable`=1.
  - Required: `lfsr_q` reads 2, 6, E; `timeout` pulses after edge k+4; `busy` falls on that same edge; no further pulses.
- Periodic: as above with `periodic`=1 → `timeout` pulses at k+4, k+8 and k+12; `busy` stays 1.
- Enable gating:
  - `enable` low for 3 cycles after the first step → `timeout` moves to k+7.
  - Match with `enable` low (`lfsr_q`=E) → pulse still issued.
- Restart and stop:
  - `start` asserted in the cycle `lfsr_q`=E → no pulse; `lfsr_q`=0; next pulse 4 cycles later.
  - `stop` in the same cycle as a match → no pulse; IDLE.
- Terminal write race:
  - `term_we` with 0x6 in the cycle `lfsr_q`=6 → no match that cycle (old terminal 0xE in use).
  - Terminal equal to SEED (0) → `timeout` high every cycle.
- Lock-up, `LFSR_TIMER_LOCKUP_EN` defined:
  - Force the state to 0xF via `SEED`=4'hF elaboration override in a dedicated bench, terminal 0xE.
  - Required: `lockup_err` pulses every cycle of RUN. Without the macro: `lockup_err`=0 and `lfsr_q` holds 0xF.
